// File: rtl/pid_cfg_pkg.sv
// pid_cfg_pkg: shared definitions for the UART PID tuning command parser.
//   - gain_t      : Q8.8 unsigned gain (integer bits 7:0, fraction bits -1:-8)
//   - SYNC_BYTE / ACK / NAK framing and response codes
//   - cfg_addr_e  : register address map (ADDR[6:0])
//   - pid_state_e : packet parser FSM states
//   - reset values of the configuration registers
//   - calc_csum   : packet checksum helper
package pid_cfg_pkg;

  typedef logic [7:-8] gain_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [6:0] {
    ADDR_KP_TACH   = 7'h00,
    ADDR_KI_TACH   = 7'h01,
    ADDR_KD_TACH   = 7'h02,
    ADDR_KP_WALL   = 7'h03,
    ADDR_KI_WALL   = 7'h04,
    ADDR_KD_WALL   = 7'h05,
    ADDR_DIST      = 7'h06,
    ADDR_BASE_TACH = 7'h07
  } cfg_addr_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CSUM = 3'd4,
    ST_RESP = 3'd5
  } pid_state_e;

  localparam gain_t      KP_TACH_RST   = 16'h0F00;
  localparam gain_t      KP_WALL_RST   = 16'h0040;
  localparam gain_t      GAIN_ZERO     = 16'h0000;
  localparam logic [6:0] DIST_RST      = 7'd30;
  localparam logic [7:0] BASE_TACH_RST = 8'd12;

  // Packet checksum: XOR of address and both data bytes.
  function automatic logic [7:0] calc_csum(input logic [7:0] addr,
                                           input logic [7:0] d_hi,
                                           input logic [7:0] d_lo);
    return addr ^ d_hi ^ d_lo;
  endfunction

endpackage

// File: rtl/pid_cmd_parser_timeout.sv
// cmd_timeout_timer: inter-byte idle counter for the command parser.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : count while a packet is in progress
//   clear      : restart the count (a byte arrived)
//   expire     : high in the TIMEOUT_CLKS-th consecutive idle cycle; a clear
//                in that same cycle suppresses it, so an arriving byte wins
module cmd_timeout_timer
  import pid_cfg_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 125000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_r;

  // Idle-cycle counter; holds at its last value until the parser leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear || !enable) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_LAST) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign expire = enable && !clear && (cnt_r == CNT_LAST);

endmodule

// File: rtl/pid_cmd_parser.sv
// pid_cmd_parser: UART command parser for runtime PID tuning.
//   Packet: A5, ADDR, D_HI, D_LO, CSUM (CSUM = ADDR ^ D_HI ^ D_LO).
//   ADDR[7]=0 writes a register, ADDR[7]=1 reads it back.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rx_valid, rx_data     : received byte strobe and data
//   tx_start, tx_data     : response byte strobe and data (to uart_tx)
//   tx_done               : transmitter finished the previous byte
//   k_{p,i,d}_{tach,wall} : Q8.8 PID gains
//   distance_cm_setpoint  : wall-follower distance setpoint
//   base_tach_count       : base tach edge-count setpoint
//   cfg_update            : one-cycle pulse after any register write
//   err_count             : saturating count of NAKed or aborted packets
module pid_cmd_parser
  import pid_cfg_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 125000,
  parameter int GAIN_WIDTH   = 16,
  parameter int DIST_MIN     = 8,
  parameter int DIST_MAX     = 56
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_done,
  output logic [GAIN_WIDTH-1:0] k_p_tach,
  output logic [GAIN_WIDTH-1:0] k_i_tach,
  output logic [GAIN_WIDTH-1:0] k_d_tach,
  output logic [GAIN_WIDTH-1:0] k_p_wall,
  output logic [GAIN_WIDTH-1:0] k_i_wall,
  output logic [GAIN_WIDTH-1:0] k_d_wall,
  output logic [6:0]            distance_cm_setpoint,
  output logic [7:0]            base_tach_count,
  output logic                  cfg_update,
  output logic [7:0]            err_count
);

  pid_state_e state_r, state_s;

  logic [7:0] addr_r, dhi_r, dlo_r;
  gain_t      kp_tach_r, ki_tach_r, kd_tach_r;
  gain_t      kp_wall_r, ki_wall_r, kd_wall_r;
  logic [6:0] dist_r;
  logic [7:0] base_r;

  logic       tx_start_r;
  logic [7:0] tx_data_r;
  logic       cfg_update_r;
  logic [7:0] err_count_r;
  logic [7:0] resp_q_r [0:2];
  logic [1:0] resp_idx_r, resp_last_r;

  logic cap_addr_s, cap_dhi_s, cap_dlo_s, accept_s, tx_next_s, abort_s;
  logic csum_ok_s, addr_ok_s, dist_ok_s, is_read_s, pkt_ok_s, wr_s, nak_s;
  logic timer_en_s, expire_s;
  logic [15:0] rd_val_s;
  logic [7:0]  first_byte_s;

  assign timer_en_s = (state_r == ST_ADDR) || (state_r == ST_DHI) ||
                      (state_r == ST_DLO)  || (state_r == ST_CSUM);

  cmd_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en_s),
    .clear  (rx_valid),
    .expire (expire_s)
  );

  // Packet evaluation; the checksum byte is still on rx_data while in CSUM.
  always_comb begin
    csum_ok_s = (calc_csum(addr_r, dhi_r, dlo_r) == rx_data);
    addr_ok_s = (addr_r[6:0] <= ADDR_BASE_TACH);
    is_read_s = addr_r[7];
    if (!is_read_s && (addr_r[6:0] == ADDR_DIST)) begin
      dist_ok_s = (dlo_r >= 8'(DIST_MIN)) && (dlo_r <= 8'(DIST_MAX));
    end else begin
      dist_ok_s = 1'b1;
    end
    pkt_ok_s     = csum_ok_s && addr_ok_s && dist_ok_s;
    wr_s         = accept_s && pkt_ok_s && !is_read_s;
    nak_s        = accept_s && !pkt_ok_s;
    first_byte_s = pkt_ok_s ? ACK : NAK;
  end

  // Readback mux; narrow registers are zero-extended to 16 bits.
  always_comb begin
    rd_val_s = 16'h0000;
    case (addr_r[6:0])
      ADDR_KP_TACH:   rd_val_s = kp_tach_r;
      ADDR_KI_TACH:   rd_val_s = ki_tach_r;
      ADDR_KD_TACH:   rd_val_s = kd_tach_r;
      ADDR_KP_WALL:   rd_val_s = kp_wall_r;
      ADDR_KI_WALL:   rd_val_s = ki_wall_r;
      ADDR_KD_WALL:   rd_val_s = kd_wall_r;
      ADDR_DIST:      rd_val_s = {9'h000, dist_r};
      ADDR_BASE_TACH: rd_val_s = {8'h00, base_r};
      default:        rd_val_s = 16'h0000;
    endcase
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_s    = state_r;
    cap_addr_s = 1'b0;
    cap_dhi_s  = 1'b0;
    cap_dlo_s  = 1'b0;
    accept_s   = 1'b0;
    tx_next_s  = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_s = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          cap_addr_s = 1'b1;
          state_s    = ST_DHI;
        end else if (expire_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DHI: begin
        if (rx_valid) begin
          cap_dhi_s = 1'b1;
          state_s   = ST_DLO;
        end else if (expire_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DHI;
        end
      end
      ST_DLO: begin
        if (rx_valid) begin
          cap_dlo_s = 1'b1;
          state_s   = ST_CSUM;
        end else if (expire_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DLO;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          accept_s = 1'b1;
          state_s  = ST_RESP;
        end else if (expire_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CSUM;
        end
      end
      ST_RESP: begin
        // Incoming bytes are ignored here; only tx_done advances the response.
        if (tx_done && (resp_idx_r == resp_last_r)) begin
          state_s = ST_IDLE;
        end else if (tx_done) begin
          tx_next_s = 1'b1;
          state_s   = ST_RESP;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Packet field capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= 8'h00;
      dhi_r  <= 8'h00;
      dlo_r  <= 8'h00;
    end else begin
      if (cap_addr_s) addr_r <= rx_data;
      if (cap_dhi_s)  dhi_r  <= rx_data;
      if (cap_dlo_s)  dlo_r  <= rx_data;
    end
  end

  // Configuration register file, written on the CSUM-accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kp_tach_r <= KP_TACH_RST;
      ki_tach_r <= GAIN_ZERO;
      kd_tach_r <= GAIN_ZERO;
      kp_wall_r <= KP_WALL_RST;
      ki_wall_r <= GAIN_ZERO;
      kd_wall_r <= GAIN_ZERO;
      dist_r    <= DIST_RST;
      base_r    <= BASE_TACH_RST;
    end else if (wr_s) begin
      case (addr_r[6:0])
        ADDR_KP_TACH:   kp_tach_r <= {dhi_r, dlo_r};
        ADDR_KI_TACH:   ki_tach_r <= {dhi_r, dlo_r};
        ADDR_KD_TACH:   kd_tach_r <= {dhi_r, dlo_r};
        ADDR_KP_WALL:   kp_wall_r <= {dhi_r, dlo_r};
        ADDR_KI_WALL:   ki_wall_r <= {dhi_r, dlo_r};
        ADDR_KD_WALL:   kd_wall_r <= {dhi_r, dlo_r};
        ADDR_DIST:      dist_r    <= dlo_r[6:0];
        ADDR_BASE_TACH: base_r    <= dlo_r;
        default: begin
        end
      endcase
    end
  end

  // Write-notification pulse and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_update_r <= 1'b0;
      err_count_r  <= 8'h00;
    end else begin
      cfg_update_r <= wr_s;
      if ((nak_s || abort_s) && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'h01;
      end
    end
  end

  // Response queue and transmit handshake; the first byte goes out as RESP
  // is entered, each later byte only after the previous tx_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q_r[0] <= 8'h00;
      resp_q_r[1] <= 8'h00;
      resp_q_r[2] <= 8'h00;
      resp_idx_r  <= 2'd0;
      resp_last_r <= 2'd0;
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
    end else if (accept_s) begin
      resp_q_r[0] <= first_byte_s;
      resp_q_r[1] <= rd_val_s[15:8];
      resp_q_r[2] <= rd_val_s[7:0];
      resp_idx_r  <= 2'd0;
      resp_last_r <= (pkt_ok_s && is_read_s) ? 2'd2 : 2'd0;
      tx_start_r  <= 1'b1;
      tx_data_r   <= first_byte_s;
    end else if (tx_next_s) begin
      resp_idx_r  <= resp_idx_r + 2'd1;
      tx_start_r  <= 1'b1;
      tx_data_r   <= resp_q_r[resp_idx_r + 2'd1];
    end else begin
      tx_start_r  <= 1'b0;
    end
  end

  assign tx_start             = tx_start_r;
  assign tx_data              = tx_data_r;
  assign k_p_tach             = kp_tach_r;
  assign k_i_tach             = ki_tach_r;
  assign k_d_tach             = kd_tach_r;
  assign k_p_wall             = kp_wall_r;
  assign k_i_wall             = ki_wall_r;
  assign k_d_wall             = kd_wall_r;
  assign distance_cm_setpoint = dist_r;
  assign base_tach_count      = base_r;
  assign cfg_update           = cfg_update_r;
  assign err_count            = err_count_r;

endmodule

// File: tb/tb_pid_cmd_parser.sv
// tb_pid_cmd_parser: directed + randomized bench for pid_cmd_parser with a
// register-map reference model and a uart_tx-like responder.
module tb_pid_cmd_parser;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [15:0] k_p_tach, k_i_tach, k_d_tach, k_p_wall, k_i_wall, k_d_wall;
  logic [6:0]  distance_cm_setpoint;
  logic [7:0]  base_tach_count;
  logic        cfg_update;
  logic [7:0]  err_count;

  pid_cmd_parser #(.TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .k_p_tach(k_p_tach), .k_i_tach(k_i_tach), .k_d_tach(k_d_tach),
    .k_p_wall(k_p_wall), .k_i_wall(k_i_wall), .k_d_wall(k_d_wall),
    .distance_cm_setpoint(distance_cm_setpoint), .base_tach_count(base_tach_count),
    .cfg_update(cfg_update), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // transmitter model state
  logic [7:0] tx_log[$];
  int  n_start = 0;
  int  proto_err = 0;
  int  cfg_cnt = 0;
  bit  busy = 1'b0;
  int  cnt = 0;
  int  tx_delay = 2;
  bit  stretch_once = 1'b0;

  // reference model
  logic [15:0] m_reg [0:7];
  int          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_reg[0] = 16'h0F00; m_reg[1] = 16'h0000; m_reg[2] = 16'h0000;
    m_reg[3] = 16'h0040; m_reg[4] = 16'h0000; m_reg[5] = 16'h0000;
    m_reg[6] = 16'd30;   m_reg[7] = 16'd12;
    m_err = 0;
  endfunction

  task automatic check_regs();
    chk("k_p_tach", k_p_tach, m_reg[0]);
    chk("k_i_tach", k_i_tach, m_reg[1]);
    chk("k_d_tach", k_d_tach, m_reg[2]);
    chk("k_p_wall", k_p_wall, m_reg[3]);
    chk("k_i_wall", k_i_wall, m_reg[4]);
    chk("k_d_wall", k_d_wall, m_reg[5]);
    chk("distance", {25'd0, distance_cm_setpoint}, m_reg[6]);
    chk("base_tach", {24'd0, base_tach_count}, m_reg[7]);
    chk("err_count", {24'd0, err_count}, m_err);
  endtask

  // uart_tx stand-in: logs bytes, answers each tx_start with a delayed tx_done
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0; tx_done = 1'b0; cnt = 0;
      end else begin
        tx_done = 1'b0;
        if (cfg_update) cfg_cnt++;
        if (tx_start) begin
          if (busy) proto_err++;
          tx_log.push_back(tx_data);
          n_start++;
          busy = 1'b1;
          cnt = stretch_once ? 20000 : tx_delay;
          stretch_once = 1'b0;
        end else if (busy) begin
          if (cnt == 0) begin
            tx_done = 1'b1; busy = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_packet(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c, input int gap, input int dhi_gap, input bit stream);
    logic [7:0] exp_q[$];
    logic [2:0] ri;
    bit ok, wr;
    int base, cfg0, budget, k;
    ri = a[2:0];
    ok = (c == (a ^ h ^ l)) && (a[6:0] < 7'd8);
    if (ok && !a[7] && a[6:0] == 7'd6 && (l < 8'd8 || l > 8'd56)) ok = 1'b0;
    wr = ok && !a[7];
    if (!ok) begin
      exp_q.push_back(8'h15);
      if (m_err < 255) m_err++;
    end else begin
      exp_q.push_back(8'h06);
      if (a[7]) begin
        exp_q.push_back(m_reg[ri][15:8]);
        exp_q.push_back(m_reg[ri][7:0]);
      end else if (ri == 3'd6) begin
        m_reg[ri] = {9'd0, l[6:0]};
      end else if (ri == 3'd7) begin
        m_reg[ri] = {8'd0, l};
      end else begin
        m_reg[ri] = {h, l};
      end
    end
    base   = tx_log.size();
    cfg0   = cfg_cnt;
    budget = stream ? 30000 : exp_q.size() * (tx_delay + 4) + 40;
    send_byte(8'hA5, gap);
    send_byte(a, gap);
    send_byte(h, dhi_gap);
    send_byte(l, gap);
    send_byte(c, gap);
    chk("cfg_update_pulse", cfg_update, wr);
    k = 0;
    while (!((tx_log.size() >= base + exp_q.size()) && !busy) && budget > 0) begin
      if (stream) begin
        case (k % 5)
          0: send_byte(8'hA5, 0);
          1: send_byte(8'h00, 0);
          2: send_byte(8'h12, 0);
          3: send_byte(8'h34, 0);
          default: send_byte(8'h26, 0);
        endcase
        k++;
      end else begin
        @(negedge clk);
      end
      budget--;
    end
    chk("resp_wait_in_budget", budget > 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("resp_len", tx_log.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < tx_log.size()) chk("resp_byte", tx_log[base + i], exp_q[i]);
    end
    chk("cfg_update_count", cfg_cnt - cfg0, wr);
    check_regs();
  endtask

  initial begin
    int base, s0;
    logic [7:0] a, h, l, c;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_cfg_update", cfg_update, 1'b0);
    check_regs();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // directed packets
    run_packet(8'h80, 8'h00, 8'h00, 8'h80, 0, 0, 1'b0);
    run_packet(8'h01, 8'h01, 8'h23, 8'h23, 0, 0, 1'b0);
    run_packet(8'h00, 8'h12, 8'h34, 8'h00, 1, 1, 1'b0);
    run_packet(8'h06, 8'h00, 8'h05, 8'h03, 0, 0, 1'b0);
    run_packet(8'h06, 8'h00, 8'h28, 8'h2E, 0, 0, 1'b0);
    run_packet(8'h08, 8'h00, 8'h00, 8'h08, 0, 0, 1'b0);
    run_packet(8'h86, 8'h00, 8'h00, 8'h86, 0, 0, 1'b0);
    run_packet(8'h06, 8'h00, 8'h38, 8'h3E, 0, 0, 1'b0);
    run_packet(8'h06, 8'h00, 8'h39, 8'h3F, 0, 0, 1'b0);
    run_packet(8'h06, 8'h00, 8'h08, 8'h0E, 0, 0, 1'b0);
    run_packet(8'h06, 8'h00, 8'h07, 8'h01, 0, 0, 1'b0);

    // timeout: idle for TO cycles after ADDR aborts silently
    base = tx_log.size();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, TO);
    send_byte(8'h34, 0);
    send_byte(8'h25, 0);
    repeat (10) @(negedge clk);
    m_err++;
    chk("timeout_no_tx", tx_log.size() - base, 0);
    check_regs();
    // byte landing on the expiry cycle is accepted
    run_packet(8'h03, 8'h12, 8'h34, 8'h25, 0, TO - 1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      tx_delay = $urandom_range(0, 6);
      a = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 9))};
      h = 8'($urandom_range(0, 255));
      l = (a[6:0] == 7'd6) ? 8'($urandom_range(0, 70)) : 8'($urandom_range(0, 255));
      c = a ^ h ^ l;
      if ($urandom_range(0, 9) == 0) c = c ^ 8'h5A;
      run_packet(a, h, l, c, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
    end

    // stretched tx_done while rx keeps streaming
    tx_delay = 3;
    s0 = n_start;
    stretch_once = 1'b1;
    run_packet(8'h81, 8'h00, 8'h00, 8'h81, 0, 0, 1'b1);
    chk("stretch_tx_starts", n_start - s0, 3);

    // error counter saturation
    tx_delay = 0;
    for (int n = 0; n < 260; n++) run_packet(8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 1'b0);
    chk("err_saturated", err_count, 8'hFF);

    // reset in the middle of a response
    tx_delay = 50;
    base = tx_log.size();
    send_byte(8'hA5, 0); send_byte(8'h80, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h80, 0);
    for (int i = 0; i < 20 && tx_log.size() == base; i++) @(negedge clk);
    chk("mid_resp_started", tx_log.size() - base, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_tx_start", tx_start, 1'b0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_cfg_update", cfg_update, 1'b0);
    check_regs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    chk("no_tx_after_reset", tx_log.size() - base, 1);
    check_regs();
    chk("tx_protocol", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
